// File: rtl/tdm_buffer_bridge_if.sv
// tdm_buffer_bridge_if -- groups the TDM pins, the MCU serial pins and the
// status/interrupt lines of tdm_buffer_bridge into one bundle.
//   TDM : c4, f0, data_from_dt (in to bridge), data_to_dt (out)
//   MCU : clk_from_stm, data_from_stm, int_ack (in), data_to_stm (out)
//   misc: loopback (in), cpu_int, overrun, frame_err (out)
// slave  = bridge side, master = board/MCU side driving the bridge.
interface tdm_buffer_bridge_if;
  logic c4;
  logic f0;
  logic data_from_dt;
  logic data_to_dt;
  logic clk_from_stm;
  logic data_from_stm;
  logic data_to_stm;
  logic int_ack;
  logic loopback;
  logic cpu_int;
  logic overrun;
  logic frame_err;

  modport slave (
    input  c4, f0, data_from_dt, clk_from_stm, data_from_stm, int_ack, loopback,
    output data_to_dt, data_to_stm, cpu_int, overrun, frame_err
  );

  modport master (
    output c4, f0, data_from_dt, clk_from_stm, data_from_stm, int_ack, loopback,
    input  data_to_dt, data_to_stm, cpu_int, overrun, frame_err
  );
endinterface

// File: rtl/tdm_buffer_bridge.sv
// tdm_buffer_bridge -- ping-pong bit buffer between a TDM serial link and an
// MCU serial port, all in the clk50 domain.
//   clk50   : sole clock, rising edge
//   reset_n : synchronous active-low reset (clears banks too)
//   bus     : tdm_buffer_bridge_if.slave (TDM pins, MCU pins, status)
// The TDM side fills rx[sel] / drains tx[sel]; the MCU side works on the
// opposite bank. After NUM_FRAMES frames the banks swap and cpu_int is raised.
module tdm_buffer_bridge #(
  parameter int BITS_PER_FRAME = 32,
  parameter int NUM_FRAMES     = 8,
  parameter int C4_PER_BIT     = 2
) (
  input logic              clk50,
  input logic              reset_n,
  tdm_buffer_bridge_if.slave bus
);
  localparam int DEPTH = BITS_PER_FRAME * NUM_FRAMES;
  localparam int PW    = (DEPTH > 1)          ? $clog2(DEPTH)          : 1;
  localparam int BW    = (BITS_PER_FRAME > 1) ? $clog2(BITS_PER_FRAME) : 1;
  localparam int FW    = (NUM_FRAMES > 1)     ? $clog2(NUM_FRAMES)     : 1;
  localparam int HW    = (C4_PER_BIT > 1)     ? $clog2(C4_PER_BIT)     : 1;

  // 2-flop synchronizers; index 1 is the usable value
  logic [1:0] c4_s, f0_s, dt_s, sck_s, sd_s;
  logic       c4_d, sck_d;

  logic [HW-1:0] phase;
  logic [BW-1:0] bit_idx;
  logic [FW-1:0] frame_idx;
  logic          sel;
  logic [PW-1:0] ptr;
  logic [1:0][DEPTH-1:0] rx_mem, tx_mem;

  logic data_to_dt, data_to_stm, cpu_int, overrun, frame_err;

  logic          c4_edge, sck_edge, last_phase, last_bit, last_frame, swap;
  logic          mcu_bank;
  logic [PW-1:0] idx, mcu_ptr;

  always_comb begin
    c4_edge    = c4_s[1] & ~c4_d;
    sck_edge   = sck_s[1] & ~sck_d;
    last_phase = (phase == HW'(C4_PER_BIT - 1));
    last_bit   = (bit_idx == BW'(BITS_PER_FRAME - 1));
    last_frame = (frame_idx == FW'(NUM_FRAMES - 1));
    swap       = f0_s[1] & c4_edge & last_phase & last_bit & last_frame;
    idx        = PW'(frame_idx) * PW'(BITS_PER_FRAME) + PW'(bit_idx);
    // a swap in this cycle hands the just-filled bank to the MCU at index 0
    mcu_bank   = swap ? sel : ~sel;
    mcu_ptr    = swap ? '0 : ptr;
  end

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      c4_s <= '0; f0_s <= '0; dt_s <= '0; sck_s <= '0; sd_s <= '0;
      c4_d <= 1'b0; sck_d <= 1'b0;
      phase <= '0; bit_idx <= '0; frame_idx <= '0; sel <= 1'b0; ptr <= '0;
      rx_mem <= '0; tx_mem <= '0;
      data_to_dt <= 1'b0; data_to_stm <= 1'b0;
      cpu_int <= 1'b0; overrun <= 1'b0; frame_err <= 1'b0;
    end else begin
      c4_s  <= {c4_s[0],  bus.c4};
      f0_s  <= {f0_s[0],  bus.f0};
      dt_s  <= {dt_s[0],  bus.data_from_dt};
      sck_s <= {sck_s[0], bus.clk_from_stm};
      sd_s  <= {sd_s[0],  bus.data_from_stm};
      c4_d  <= c4_s[1];
      sck_d <= sck_s[1];

      frame_err <= 1'b0;
      if (!f0_s[1]) begin
        // f0 low with a partial frame in flight: abort, recapture same frame
        if (phase != '0 || bit_idx != '0) frame_err <= 1'b1;
        phase   <= '0;
        bit_idx <= '0;
      end else if (c4_edge) begin
        if (phase == '0) begin
          rx_mem[sel][idx] <= dt_s[1];
          data_to_dt       <= bus.loopback ? dt_s[1] : tx_mem[sel][idx];
        end
        if (last_phase) begin
          phase <= '0;
          if (last_bit) begin
            bit_idx   <= '0;
            frame_idx <= last_frame ? '0 : frame_idx + 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end else begin
          phase <= phase + 1'b1;
        end
      end

      if (swap) begin
        sel     <= ~sel;
        cpu_int <= 1'b1;
        // a coincident ack counts as servicing the previous bank
        if (cpu_int && !bus.int_ack) overrun <= 1'b1;
      end else if (bus.int_ack) begin
        cpu_int <= 1'b0;
        overrun <= 1'b0;
      end

      if (sck_edge) begin
        data_to_stm                <= rx_mem[mcu_bank][mcu_ptr];
        tx_mem[mcu_bank][mcu_ptr]  <= sd_s[1];
        ptr <= (mcu_ptr == PW'(DEPTH - 1)) ? '0 : mcu_ptr + 1'b1;
      end else if (swap) begin
        ptr <= '0;
      end
    end
  end

  assign bus.data_to_dt  = data_to_dt;
  assign bus.data_to_stm = data_to_stm;
  assign bus.cpu_int     = cpu_int;
  assign bus.overrun     = overrun;
  assign bus.frame_err   = frame_err;
endmodule
